// File: rtl/ccu_pkg.sv
// Shared types and helpers for the CCU address-channel arbiter.
package ccu_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ccu_arb_state_e;

    // Width needed to hold a port index; never less than one bit.
    function automatic int ccu_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round-robin pointer following a grant to port sel out of n ports.
    function automatic int ccu_rr_next(input int sel, input int n);
        return (sel >= n - 1) ? 0 : sel + 1;
    endfunction

endpackage

// File: rtl/ccu_idx_fifo.sv
// In-order FIFO of granted port indices. No fall-through: a push into an
// empty FIFO shows on data_o one cycle later. A push while full is dropped
// even if a pop happens in the same cycle; a pop while empty is ignored.
module ccu_idx_fifo #(
    parameter int Depth = 4,
    parameter int IdxW  = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [IdxW-1:0] data_i,
    input  logic            pop_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [IdxW-1:0] data_o
);

    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [IdxW-1:0] mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Storage is not reset, so mask the head while empty.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            if (do_pop)
                rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop)
                cnt_q <= cnt_q + CntW'(1);
            else if (do_pop && !do_push)
                cnt_q <= cnt_q - CntW'(1);
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        if (do_push)
            mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ccu_ax_arbiter.sv
// Round-robin merge of NoPorts gated AW/AR requests into one registered
// stream toward the CCU, with an optional in-order FIFO of granted port
// indices for W-data and response routing.
// Optional feature macro: CCU_AX_ARB_IDX_FIFO_EN (index FIFO present).
//
//   state | meaning
//   ------+---------------------------------------------
//   EMPTY | output register free, mst_valid_o = 0
//   FULL  | output register holds a beat, mst_valid_o = 1
module ccu_ax_arbiter
    import ccu_pkg::*;
#(
    parameter  int  NoPorts      = 4,
    parameter  int  IdxFifoDepth = 4,
    parameter  type ax_t         = logic,
    localparam int  IdxW         = ccu_idx_width(NoPorts)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NoPorts-1:0] slv_valid_i,
    output logic [NoPorts-1:0] slv_ready_o,
    input  ax_t                slv_ax_i [NoPorts],
    output logic               mst_valid_o,
    input  logic               mst_ready_i,
    output ax_t                mst_ax_o,
    output logic [IdxW-1:0]    mst_idx_o,
    output logic               idx_valid_o,
    input  logic               idx_ready_i,
    output logic [IdxW-1:0]    idx_o
);

    ccu_arb_state_e  state_q, state_d;
    logic [IdxW-1:0] rr_q, sel, mst_idx_q;
    ax_t             mst_ax_q;
    logic            can_load, fifo_full, grant;

    // First valid port at or after rr_q, wrapping modulo NoPorts.
    always_comb begin
        int cand;
        logic found;
        sel   = rr_q;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NoPorts; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NoPorts)
                cand = cand - NoPorts;
            if (!found && slv_valid_i[cand[IdxW-1:0]]) begin
                found = 1'b1;
                sel   = cand[IdxW-1:0];
            end
        end
    end

    // Ready is held low during reset so no handshake completes on that edge.
    assign can_load    = (state_q == EMPTY) || mst_ready_i;
    assign grant       = !rst_i && can_load && (|slv_valid_i) && !fifo_full;
    assign slv_ready_o = grant ? (NoPorts'(1) << sel) : '0;

    // Next state of the output register.
    always_comb begin
        state_d = state_q;
        if (grant)
            state_d = FULL;
        else if (state_q == FULL && mst_ready_i)
            state_d = EMPTY;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    // Payload and index register; held while the CCU stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mst_ax_q  <= '0;
            mst_idx_q <= '0;
        end else if (grant) begin
            mst_ax_q  <= slv_ax_i[sel];
            mst_idx_q <= sel;
        end
    end

    // Round-robin pointer advances past the granted port.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            rr_q <= '0;
        else if (grant)
            rr_q <= IdxW'(ccu_rr_next(int'(sel), NoPorts));
    end

    assign mst_valid_o = (state_q == FULL);
    assign mst_ax_o    = mst_ax_q;
    assign mst_idx_o   = mst_idx_q;

`ifdef CCU_AX_ARB_IDX_FIFO_EN
    logic fifo_empty;

    ccu_idx_fifo #(
        .Depth (IdxFifoDepth),
        .IdxW  (IdxW)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .data_i  (sel),
        .pop_i   (idx_ready_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_o  (idx_o)
    );

    assign idx_valid_o = !fifo_empty;
`else
    // AR build: R routing uses IDs, so no index tracking or backpressure.
    logic unused_idx_ready;

    assign unused_idx_ready = idx_ready_i;
    assign fifo_full        = 1'b0;
    assign idx_valid_o      = 1'b0;
    assign idx_o            = '0;
`endif

endmodule

// File: tb/tb_ccu_ax_arbiter.sv
// Bench for ccu_ax_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a queue-based reference model.
module tb_ccu_ax_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 2;
    localparam int AXW   = 16;
`ifdef CCU_AX_ARB_IDX_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    typedef logic [AXW-1:0] ax_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] slv_valid, slv_ready;
    ax_t          slv_ax [N];
    logic         mst_valid, mst_ready;
    ax_t          mst_ax;
    logic [1:0]   mst_idx, idx_o;
    logic         idx_valid, idx_ready;

    ccu_ax_arbiter #(
        .NoPorts      (N),
        .IdxFifoDepth (DEPTH),
        .ax_t         (ax_t)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .slv_valid_i (slv_valid),
        .slv_ready_o (slv_ready),
        .slv_ax_i    (slv_ax),
        .mst_valid_o (mst_valid),
        .mst_ready_i (mst_ready),
        .mst_ax_o    (mst_ax),
        .mst_idx_o   (mst_idx),
        .idx_valid_o (idx_valid),
        .idx_ready_i (idx_ready),
        .idx_o       (idx_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: output slot, round-robin pointer, index queue.
    int  m_rr;
    bit  m_valid;
    ax_t m_ax;
    int  m_idx;
    int  m_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    function automatic void model_reset();
        m_rr    = 0;
        m_valid = 1'b0;
        m_ax    = '0;
        m_idx   = 0;
        m_q.delete();
    endfunction

    // One cycle: drive at negedge, check, then advance the model to the edge.
    task automatic step(input logic r, input logic [N-1:0] v, input logic mr, input logic ir);
        int     s;
        bit     full, grant;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        rst       = r;
        slv_valid = v;
        mst_ready = mr;
        idx_ready = ir;
        for (int p = 0; p < N; p++) slv_ax[p] = ax_t'($urandom);
        #1;
        s         = pick(v);
        full      = FIFO_EN && (m_q.size() == DEPTH);
        grant     = !r && (!m_valid || mr) && (v != 0) && !full;
        exp_ready = grant ? (N'(1) << s) : '0;
        chk("slv_ready", 32'(slv_ready), 32'(exp_ready));
        chk("mst_valid", 32'(mst_valid), 32'(m_valid));
        chk("mst_ax",    32'(mst_ax),    32'(m_ax));
        chk("mst_idx",   32'(mst_idx),   32'(m_idx));
        chk("idx_valid", 32'(idx_valid), 32'(m_q.size() > 0));
        chk("idx_o",     32'(idx_o),     32'((m_q.size() > 0) ? m_q[0] : 0));
        if (r) begin
            model_reset();
        end else begin
            if (FIFO_EN && ir && m_q.size() > 0) void'(m_q.pop_front());
            if (grant) begin
                if (FIFO_EN) m_q.push_back(s);
                m_valid = 1'b1;
                m_ax    = slv_ax[s];
                m_idx   = s;
                m_rr    = (s + 1) % N;
            end else if (m_valid && mr) begin
                m_valid = 1'b0;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        slv_valid = '0;
        mst_ready = 1'b0;
        idx_ready = 1'b0;
        for (int p = 0; p < N; p++) slv_ax[p] = '0;
        repeat (2) @(posedge clk);
        model_reset();

        step(1, '0, 0, 0);
        // round-robin wrap 0,1,2,3,0
        repeat (6) step(0, 4'hF, 1, 1);
        // backpressure hold on port 2
        step(1, '0, 0, 0);
        step(0, 4'b0100, 0, 0);
        repeat (5) step(0, 4'hF, 0, 0);
        repeat (2) step(0, '0, 1, 1);
        // index FIFO full, then one pop frees one grant
        step(1, '0, 0, 0);
        repeat (5) step(0, 4'b1011, 1, 0);
        step(0, 4'b1011, 1, 1);
        repeat (3) step(0, 4'b1011, 1, 0);
        // valid dropped without handshake while output held
        step(1, '0, 0, 0);
        step(0, 4'b0001, 0, 1);
        step(0, 4'b0010, 0, 1);
        step(0, 4'b1000, 1, 1);
        step(0, '0, 1, 1);
        // reset with pending output and FIFO entries
        repeat (3) step(0, 4'hF, 0, 0);
        step(1, 4'hF, 1, 0);
        repeat (3) step(0, 4'hF, 1, 1);
        // random traffic
        repeat (600)
            step(($urandom % 32) == 0, N'($urandom), ($urandom % 4) != 0, ($urandom % 2) == 0);
        repeat (4) step(0, '0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccu_ax_arbiter.md
# ccu_ax_arbiter

Round-robin arbiter for one AXI/ACE address channel (AW or AR) in the coherency path. It sits directly downstream of the per-port overlap-gating dispatch stage and feeds the single address input of the CCU. It merges `NoPorts` gated address requests into one registered output stream. It also records the granting port index in an in-order FIFO, so the W-data and response routing logic knows which port owns each accepted transaction.

## Interface
- `NoPorts`, 4, number of upstream ports; must be ≥ 2.
- `IdxFifoDepth`, 4, depth of the port-index FIFO; must be ≥ 1.
- `ax_t`, logic, address-channel payload type (AW or AR struct).
- `IdxW`, `$clog2(NoPorts)`, derived localparam; not overridable.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `slv_valid_i` in `NoPorts`: per-port address valid, already gated by the dispatch stage.
- `slv_ready_o` out `NoPorts`: per-port ready; one-hot or zero.
- `slv_ax_i` in `NoPorts` × `ax_t`: per-port payload.
- `mst_valid_o` out 1: valid toward the CCU.
- `mst_ready_i` in 1: ready from the CCU.
- `mst_ax_o` out `ax_t`: registered payload.
- `mst_idx_o` out `IdxW`: port index of `mst_ax_o`.
- `idx_valid_o` out 1: index FIFO is not empty.
- `idx_ready_i` in 1: pop strobe from the W/response router.
- `idx_o` out `IdxW`: head of the index FIFO.

## Operation
- **Output register state machine**, two states:
  - EMPTY: `mst_valid_o` = 0.
  - FULL: `mst_valid_o` = 1.
- **`can_load`**: (state == EMPTY) or (state == FULL and `mst_ready_i`).
- **Grant**:
  - A grant occurs when `can_load`, `|slv_valid_i`, and the index FIFO is not full.
  - The selected port `sel` is the first `i` with `slv_valid_i[i]` set, searching `rr_q`, `rr_q+1`, … modulo `NoPorts`.
  - On grant, `slv_ready_o[sel]` = 1 in the same cycle. All other ready bits are 0.
- **`slv_ready_o` combinational dependencies**: it depends on `slv_valid_i`, `mst_ready_i`, state and FIFO count. It must never depend on `idx_ready_i`.
- **On grant (next edge)**:
  - `mst_ax_o` ← `slv_ax_i[sel]`; `mst_idx_o` ← `sel`; state ← FULL.
  - `sel` is pushed into the FIFO.
  - `rr_q` ← `sel+1`, wrapping to 0 when `sel` = `NoPorts-1`.
- **Other transitions**:
  - FULL with `mst_ready_i` and no grant → EMPTY.
  - FULL without `mst_ready_i`: state and payload are held stable (AXI stability rule).
  - `rr_q` is unchanged without a grant.
- **Index FIFO**:
  - Counter width is `$clog2(IdxFifoDepth+1)`; read/write pointers wrap at `IdxFifoDepth`.
  - Pop happens on `idx_valid_o & idx_ready_i`.
  - When full, a push is blocked even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full and not empty leaves the count unchanged.
  - A push into an empty FIFO becomes visible on `idx_o` the next cycle (no fall-through).
  - A pop while empty is ignored.
- **Upstream valid drop**: an upstream valid may drop without a handshake, because the dispatch stage can mask it. Nothing is latched in that case; arbitration is re-evaluated every cycle.

## Timing
- **Reset (`rst_i` high at an edge)**:
  - state = EMPTY, `rr_q` = 0, FIFO count = 0, pointers = 0.
  - `mst_valid_o` = 0, `mst_ax_o` = '0, `mst_idx_o` = 0, `idx_valid_o` = 0, `idx_o` = 0.
- **During reset**: `slv_ready_o` is forced to all-zero while `rst_i` is high.
- **Reset mid-operation**: a pending output and all FIFO entries are discarded; no handshake completes in that cycle.
- **Latency**: upstream handshake to `mst_valid_o` is 1 cycle. Upstream handshake to `idx_valid_o` is 1 cycle.
- **Throughput**: 1 grant per cycle when the CCU keeps `mst_ready_i` high and the FIFO drains.

## Configuration
- **Macro**: `CCU_AX_ARB_IDX_FIFO_EN`.
- **Defined**: the index FIFO and its backpressure on grants are present, as described above.
- **Undefined**:
  - No FIFO is instantiated.
  - `idx_valid_o` = 0 and `idx_o` = 0 constantly; `idx_ready_i` is ignored.
  - Grants are never blocked by FIFO state.
  - This build is intended for the AR channel, where R routing uses IDs.

## Structure
- **`ccu_pkg`** holds:
  - the state enum `ccu_arb_state_e` (EMPTY, FULL);
  - the helper function `ccu_rr_next(sel, n)`;
  - the index-width helper function.
- **Sub-module `ccu_idx_fifo`**: parameterised by `Depth` and `IdxW`, with push/pop, full/empty and a synchronous active-high reset. It is instantiated only under the macro.

## Test plan
- **Round-robin wrap**: `NoPorts`=4, all valid constantly, `mst_ready_i`=1, `idx_ready_i`=1 → grants 0,1,2,3,0; `mst_idx_o` follows one cycle later; `rr_q` wraps from 3 to 0.
- **Backpressure hold**: port 2 is granted and `mst_ready_i`=0 for 5 cycles → `mst_ax_o` and `mst_idx_o` stay stable, all `slv_ready_o` stay 0, and FULL holds.
- **FIFO full**: `IdxFifoDepth`=2, `idx_ready_i`=0, ports 0/1/3 valid → exactly 2 grants, then `slv_ready_o` stays 0. Asserting `idx_ready_i` for one cycle re-enables one grant on the following cycle.
- **Valid drop**: port 1 valid for 1 cycle while the output is held FULL, then dropped → no grant to port 1; the next grant goes to the next valid port.
- **Mid-operation reset**: FIFO holds 3 entries and `mst_valid_o`=1, then `rst_i` is pulsed for 1 cycle → all outputs are 0 the next cycle and the first grant afterwards is port 0 (given all ports valid).
- **Macro-off build**: all ports valid, `idx_ready_i`=0 → grants continue indefinitely and `idx_valid_o` is constantly 0.
